// File: rtl/gaus_sincos_gen.sv
// gaus_sincos_gen: quarter-wave ROM sine/cosine generator with direct-phase and NCO modes
module gaus_sincos_gen #(
    parameter int pPHASE_W = 11,
    parameter int pDAT_W   = 18
) (
    input  logic                iclk,
    input  logic                iresetn,
    input  logic                iclkena,
    input  logic                ival,
    input  logic                imode,
    input  logic                iclear,
    input  logic [pPHASE_W-1:0] iphase,
    input  logic [pPHASE_W-1:0] ifreq,
    output logic                oval,
    output logic [pPHASE_W-1:0] ophase,
    output logic [pDAT_W-1:0]   ocos,
    output logic [pDAT_W-1:0]   osin
);
    localparam int  AW = pPHASE_W - 2;
    localparam int  N  = 1 << AW;
    localparam int  A  = (1 << (pDAT_W - 1)) - 1;
    localparam real PI = 3.14159265358979323846;

    logic [pDAT_W-1:0]   rom [N];
    logic [pPHASE_W-1:0] acc, acc_next, sel_phase;
    logic                v1, v2, v3;
    logic [pPHASE_W-1:0] p1, p2, p3;
    logic [1:0]          q2, q3;
    logic [AW-1:0]       ca2, sa2;
    logic                zs2;
    logic [pDAT_W-1:0]   c3, s3, cos_n, sin_n;

    // Quarter-wave cosine table, rounded to nearest; every entry is in [0, A]
    for (genvar k = 0; k < N; k++) begin : g_rom
        localparam int V = $rtoi(real'(A) * $cos(real'(k) * PI / real'(2 * N)) + 0.5);
        assign rom[k] = pDAT_W'(V);
    end

    // Phase used by this sample and the accumulator value after it; clear wins over accumulate
    always_comb begin
        sel_phase = (imode && !iclear) ? acc + iphase : iphase;
        acc_next  = imode ? (iclear ? ifreq : acc + ifreq) : (iclear ? '0 : acc);
    end

    // Accumulator only moves on valid enabled samples, never on bubbles
    always_ff @(posedge iclk or negedge iresetn) begin
        if (!iresetn)
            acc <= '0;
        else if (iclkena && ival)
            acc <= acc_next;
    end

    // Stage 1 phase select and stage 2 quadrant fold; sin address N-i wraps to 0 at i=0 and is masked by zs
    always_ff @(posedge iclk or negedge iresetn) begin
        if (!iresetn) begin
            v1  <= 1'b0;
            p1  <= '0;
            v2  <= 1'b0;
            p2  <= '0;
            q2  <= '0;
            ca2 <= '0;
            sa2 <= '0;
            zs2 <= 1'b0;
        end else if (iclkena) begin
            v1  <= ival;
            p1  <= sel_phase;
            v2  <= v1;
            p2  <= p1;
            q2  <= p1[pPHASE_W-1:pPHASE_W-2];
            ca2 <= p1[AW-1:0];
            sa2 <= -p1[AW-1:0];
            zs2 <= (p1[AW-1:0] == '0);
        end
    end

    // Stage 3 dual-port ROM read, quadrant and phase carried alongside
    always_ff @(posedge iclk or negedge iresetn) begin
        if (!iresetn) begin
            v3 <= 1'b0;
            p3 <= '0;
            q3 <= '0;
            c3 <= '0;
            s3 <= '0;
        end else if (iclkena) begin
            v3 <= v2;
            p3 <= p2;
            q3 <= q2;
            c3 <= rom[ca2];
            s3 <= zs2 ? '0 : rom[sa2];
        end
    end

    // Quadrant sign/swap; magnitudes never exceed A so negation cannot overflow
    always_comb begin
        cos_n = (q3 == 2'd0) ? c3 : (q3 == 2'd1) ? -s3 : (q3 == 2'd2) ? -c3 : s3;
        sin_n = (q3 == 2'd0) ? s3 : (q3 == 2'd1) ? c3  : (q3 == 2'd2) ? -s3 : -c3;
    end

    // Stage 4 output register, all fields aligned to oval
    always_ff @(posedge iclk or negedge iresetn) begin
        if (!iresetn) begin
            oval   <= 1'b0;
            ophase <= '0;
            ocos   <= '0;
            osin   <= '0;
        end else if (iclkena) begin
            oval   <= v3;
            ophase <= p3;
            ocos   <= cos_n;
            osin   <= sin_n;
        end
    end
endmodule

// File: tb/tb_gaus_sincos_gen.sv
// tb_gaus_sincos_gen: randomized and directed check of gaus_sincos_gen against a real-valued reference
module tb_gaus_sincos_gen;
    localparam int  W  = 11;
    localparam int  D  = 18;
    localparam int  A  = 131071;
    localparam real PI = 3.14159265358979323846;

    logic                iclk = 1'b0, iresetn = 1'b0, iclkena = 1'b0;
    logic                ival = 1'b0, imode = 1'b0, iclear = 1'b0;
    logic [W-1:0]        iphase = '0, ifreq = '0;
    logic                oval;
    logic [W-1:0]        ophase;
    logic signed [D-1:0] ocos, osin;

    int checks = 0, passed = 0;
    int macc = 0, ecnt = 3;
    bit hv [8192];
    int hp [8192];

    always #5 iclk = ~iclk;

    gaus_sincos_gen #(.pPHASE_W(W), .pDAT_W(D)) dut (
        .iclk(iclk), .iresetn(iresetn), .iclkena(iclkena), .ival(ival),
        .imode(imode), .iclear(iclear), .iphase(iphase), .ifreq(ifreq),
        .oval(oval), .ophase(ophase), .ocos(ocos), .osin(osin)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic near(input string tag, input int obs, input int exp);
        checks++;
        assert (obs - exp <= 1 && exp - obs <= 1) passed++;
        else $error("FAIL %s observed=%0d expected=%0d (+-1)", tag, obs, exp);
    endtask

    function automatic int ref_val(input int p, input bit s);
        real a, x;
        a = 2.0 * PI * real'(p) / 2048.0;
        x = real'(A) * (s ? $sin(a) : $cos(a));
        return x >= 0.0 ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    endfunction

    // one clock: drive, update the reference on enabled edges, then check the sample due now
    task automatic cyc(input bit v, input bit m, input bit c, input int ph, input int fr, input bit en = 1'b1);
        int p;
        p = 0;
        ival = v; imode = m; iclear = c; iphase = W'(ph); ifreq = W'(fr); iclkena = en;
        @(posedge iclk);
        if (en) begin
            if (v) begin
                p = (m && !c) ? (macc + ph) % 2048 : ph;
                if (m) macc = c ? fr : (macc + fr) % 2048;
                else if (c) macc = 0;
            end
            ecnt++;
            hv[ecnt] = v;
            hp[ecnt] = p;
        end
        #1;
        chk("oval", 32'(oval), 32'(hv[ecnt-3]));
        if (hv[ecnt-3]) begin
            chk("ophase", 32'(ophase), hp[ecnt-3]);
            near("ocos", int'(ocos), ref_val(hp[ecnt-3], 1'b0));
            near("osin", int'(osin), ref_val(hp[ecnt-3], 1'b1));
        end
    endtask

    initial begin
        repeat (3) @(posedge iclk);
        #1;
        chk("rst_oval", 32'(oval), 0);
        chk("rst_ophase", 32'(ophase), 0);
        chk("rst_ocos", 32'(ocos), 0);
        chk("rst_osin", 32'(osin), 0);
        iresetn = 1'b1;

        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 512, 0);
        cyc(1, 0, 0, 1024, 0);
        cyc(1, 0, 0, 1536, 0);
        chk("q0_cos", 32'(ocos), 131071);
        chk("q0_sin", 32'(osin), 0);
        cyc(0, 0, 0, 0, 0);
        chk("q1_cos", 32'(ocos), 0);
        chk("q1_sin", 32'(osin), 131071);
        cyc(0, 0, 0, 0, 0);
        chk("q2_cos", 32'(ocos), -131071);
        chk("q2_sin", 32'(osin), 0);
        cyc(0, 0, 0, 0, 0);
        chk("q3_cos", 32'(ocos), 0);
        chk("q3_sin", 32'(osin), -131071);

        for (int p = 0; p < 2048; p++) cyc(1, 0, 0, p, 0);
        repeat (3) cyc(0, 0, 0, 0, 0);

        cyc(1, 1, 1, 0, 512);
        repeat (4) cyc(1, 1, 0, 0, 512);
        cyc(1, 1, 1, 256, 512);
        repeat (4) cyc(1, 1, 0, 256, 512);
        repeat (3) cyc(0, 1, 0, 0, 512);

        cyc(1, 1, 1, 0, $urandom_range(0, 2047));
        for (int k = 0; k < 600; k++)
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0,
                $urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 3) != 0);
        repeat (3) cyc(0, 0, 0, 0, 0);

        cyc(1, 1, 1, 0, 100);
        repeat (5) cyc(1, 1, 0, 0, 100);
        #2 iresetn = 1'b0;
        #1;
        chk("async_oval", 32'(oval), 0);
        chk("async_ophase", 32'(ophase), 0);
        chk("async_ocos", 32'(ocos), 0);
        chk("async_osin", 32'(osin), 0);
        @(posedge iclk);
        #1 iresetn = 1'b1;
        macc = 0;
        for (int k = 0; k < 4; k++) hv[ecnt-k] = 1'b0;
        repeat (4) cyc(1, 1, 0, 0, 100);
        chk("restart_ophase", 32'(ophase), 0);
        repeat (3) cyc(0, 1, 0, 0, 100);

        cyc(1, 1, 1, 0, 700);
        cyc(1, 1, 1, 37, 5);
        cyc(1, 1, 0, 37, 5);
        cyc(0, 1, 0, 0, 5);
        cyc(0, 1, 0, 0, 5);
        chk("clear_ophase", 32'(ophase), 37);
        cyc(0, 1, 0, 0, 5);
        chk("after_clear_ophase", 32'(ophase), 42);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
